bit_fetch_ctrl: RTL and testbench

Read-side sequencer for the 32-bit word FIFO in the bit-extraction datapath. It pops words from FIFO_v into a 64-bit bit reservoir and serves variable-length requests of 0..15 bits. Each request returns its bits MSB-first, right-aligned on a 15-bit result bus. It sits between FIFO_v (data_out, empty, rd_en) and the downstream bit consumer. It replaces the ad-hoc pop logic in the top level.

---
 rtl/bit_fetch_if.sv | 23 ++
 rtl/bit_fetch_ctrl.sv | 94 +++++++++
 tb/tb_bit_fetch_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/bit_fetch_if.sv
// Word-FIFO read side and bit-request bundle for bit_fetch_ctrl.
interface bit_fetch_if;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        fifo_pop;
    logic        reqin;
    logic [3:0]  reqlen;
    logic        reqbusy;
    logic        pushout;
    logic [3:0]  lenout;
    logic [14:0] dataout;
    logic [6:0]  bitcount;

    modport master (
        output fifo_empty, fifo_data, reqin, reqlen,
        input  fifo_pop, reqbusy, pushout, lenout, dataout, bitcount
    );

    modport slave (
        input  fifo_empty, fifo_data, reqin, reqlen,
        output fifo_pop, reqbusy, pushout, lenout, dataout, bitcount
    );
endinterface

// File: rtl/bit_fetch_ctrl.sv
// Pops 32-bit FIFO words into a 64-bit left-aligned reservoir and serves
// 0..15-bit requests MSB-first, right-aligned on a 15-bit result.
module bit_fetch_ctrl (
    input  logic        clock,
    input  logic        reset,
    bit_fetch_if.slave  bus
);
    localparam int WORD_W = 32;
    localparam int BUF_W  = 2 * WORD_W;
    localparam int LEN_W  = 4;
    localparam int RES_W  = (1 << LEN_W) - 1;
    localparam int CNT_W  = 7;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t               state, state_nx;
    logic                 pop;
    logic [BUF_W-1:0]     rsv, rsv_nx, rsv_left;
    logic [CNT_W-1:0]     bc, bc_nx, bc_left, cons;
    logic [LEN_W-1:0]     pend_len, len, len_q;
    logic [RES_W-1:0]     top, data_q;
    logic                 busy, push;
    logic                 serve, cap;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // At most one word in flight; refill only when a whole word fits.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!reset && !bus.fifo_empty && bc <= 7'd32) begin
                    pop      = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: state_nx = IDLE;
        endcase
    end

    always_comb begin
        len      = busy ? pend_len : bus.reqlen;
        serve    = (busy || bus.reqin) && (bc >= {3'b000, len});
        cap      = (state == WAIT);
        cons     = serve ? {3'b000, len} : 7'd0;
        bc_left  = bc - cons;
        rsv_left = rsv << cons;
        rsv_nx   = rsv_left;
        bc_nx    = bc_left;
        // Captured word lands directly below the surviving bits.
        if (cap) begin
            rsv_nx = rsv_left
                   | ({bus.fifo_data, {WORD_W{1'b0}}} >> bc_left);
            bc_nx  = bc_left + 7'd32;
        end
        top = rsv[BUF_W-1 -: RES_W] >> (4'd15 - len);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rsv      <= '0;
            bc       <= '0;
            pend_len <= '0;
            busy     <= 1'b0;
            push     <= 1'b0;
            len_q    <= '0;
            data_q   <= '0;
        end else begin
            rsv  <= rsv_nx;
            bc   <= bc_nx;
            push <= serve;
            if (bus.reqin && !busy)
                pend_len <= bus.reqlen;
            if (serve) begin
                len_q  <= len;
                data_q <= top;
                busy   <= 1'b0;
            end else if (bus.reqin && !busy) begin
                busy <= 1'b1;
            end
        end
    end

    assign bus.fifo_pop = pop;
    assign bus.reqbusy  = busy;
    assign bus.pushout  = push;
    assign bus.lenout   = len_q;
    assign bus.dataout  = data_q;
    assign bus.bitcount = bc;
endmodule

// File: tb/tb_bit_fetch_ctrl.sv
// Directed bench for bit_fetch_ctrl with a behavioural FIFO_v model
// and a bit-stream scoreboard for the streaming phase.
module tb_bit_fetch_ctrl;
    logic clock;
    logic reset;
    bit_fetch_if bus ();

    bit_fetch_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int viol    = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO_v model: registered empty flag, data valid after the pop edge.
    logic [31:0] fq[$];
    logic        push_en;
    logic [31:0] push_word;

    always @(posedge clock) begin
        if (reset) begin
            fq.delete();
            bus.fifo_data  <= '0;
            bus.fifo_empty <= 1'b1;
        end else begin
            if (bus.fifo_pop && fq.size() > 0)
                bus.fifo_data <= fq.pop_front();
            if (push_en)
                fq.push_back(push_word);
            bus.fifo_empty <= (fq.size() == 0);
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.fifo_pop && bus.fifo_empty) viol++;
            if (bus.bitcount > 7'd64) viol++;
        end
    end

    // Scoreboard for the streaming phase.
    logic [31:0]  words [8];
    logic [255:0] sbits;
    logic [14:0]  sb_exp;
    logic         sb_on = 1'b0;
    int           sb_pos = 0;
    int           served = 0;

    always @(negedge clock) begin
        if (sb_on && bus.pushout) begin
            sb_exp = '0;
            for (int i = 0; i < int'(bus.lenout); i++)
                sb_exp = {sb_exp[13:0], sbits[sb_pos + i]};
            chk("stream_data", bus.dataout, sb_exp);
            chk("stream_len", bus.lenout, 4'd15);
            sb_pos += int'(bus.lenout);
            served++;
        end
    end

    task automatic push(input logic [31:0] w);
        push_en   = 1'b1;
        push_word = w;
        @(negedge clock);
        push_en   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic req(input logic [3:0] len, input logic [14:0] exp,
                       input logic [6:0] exp_bc, input string tag);
        int n;
        n = 0;
        bus.reqin  = 1'b1;
        bus.reqlen = len;
        @(negedge clock);
        bus.reqin = 1'b0;
        while (!bus.pushout && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_push"}, bus.pushout, 1'b1);
        chk({tag, "_len"}, bus.lenout, len);
        chk({tag, "_data"}, bus.dataout, exp);
        chk({tag, "_bc"}, bus.bitcount, exp_bc);
        chk({tag, "_busy"}, bus.reqbusy, 1'b0);
    endtask

    initial begin
        int n, np, nb;
        words = '{32'hA5C30F81, 32'hFFFFFFFF, 32'h12345678, 32'h00000000,
                  32'hDEADBEEF, 32'h80000001, 32'h5A5A5A5A, 32'hC0FFEE11};
        for (int w = 0; w < 8; w++)
            for (int b = 31; b >= 0; b--)
                sbits[w*32 + (31 - b)] = words[w][b];

        reset      = 1'b1;
        push_en    = 1'b0;
        push_word  = '0;
        bus.reqin  = 1'b0;
        bus.reqlen = '0;
        repeat (3) @(negedge clock);
        chk("rst_pop", bus.fifo_pop, 1'b0);
        chk("rst_bc", bus.bitcount, 7'd0);
        reset = 1'b0;
        @(negedge clock);

        // Pending request, then reset while the pop is in flight.
        bus.reqin  = 1'b1;
        bus.reqlen = 4'd15;
        @(negedge clock);
        bus.reqin = 1'b0;
        chk("mid_busy", bus.reqbusy, 1'b1);
        push(32'hDEADBEEF);
        n = 0;
        while (!bus.fifo_pop && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("mid_pop", bus.fifo_pop, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_push", bus.pushout, 1'b0);
        chk("mid_rst_busy", bus.reqbusy, 1'b0);
        chk("mid_rst_bc", bus.bitcount, 7'd0);
        chk("mid_rst_len", bus.lenout, 4'd0);
        chk("mid_rst_data", bus.dataout, 15'd0);
        chk("mid_rst_pop", bus.fifo_pop, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("mid_stale_bc", bus.bitcount, 7'd0);
        chk("mid_stale_busy", bus.reqbusy, 1'b0);

        // Zero-length request on an empty reservoir.
        req(4'd0, 15'h0000, 7'd0, "len0");

        // Stall on empty FIFO; a second strobe while busy is ignored.
        bus.reqin  = 1'b1;
        bus.reqlen = 4'd12;
        @(negedge clock);
        bus.reqin = 1'b0;
        np = 0;
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.pushout) np++;
            if (!bus.reqbusy) nb++;
            bus.reqin  = (i == 5);
            bus.reqlen = (i == 5) ? 4'd3 : 4'd12;
            @(negedge clock);
        end
        bus.reqin = 1'b0;
        chk("stall_push", np, 0);
        chk("stall_busy", nb, 0);
        push(32'h12345678);
        n = 1;
        while (!bus.pushout && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("stall_lat", n, 4);
        chk("stall_len", bus.lenout, 4'd12);
        chk("stall_data", bus.dataout, 15'h0123);
        chk("stall_bc", bus.bitcount, 7'd20);
        np = 0;
        repeat (10) begin
            @(negedge clock);
            if (bus.pushout) np++;
        end
        chk("stall_extra", np, 0);

        // Directed extraction across a word boundary.
        do_reset();
        push(32'hA5C30F81);
        repeat (2) @(negedge clock);
        chk("a5_bc", bus.bitcount, 7'd32);
        req(4'd4, 15'h000A, 7'd28, "a5_r4");
        req(4'd8, 15'h005C, 7'd20, "a5_r8");
        req(4'd15, 15'h187C, 7'd5, "a5_r15");
        push(32'hFFFFFFFF);
        repeat (2) @(negedge clock);
        chk("ff_bc", bus.bitcount, 7'd37);
        req(4'd8, 15'h000F, 7'd29, "ff_r8");

        // Streaming with continuous 15-bit requests.
        do_reset();
        viol       = 0;
        sb_on      = 1'b1;
        bus.reqin  = 1'b1;
        bus.reqlen = 4'd15;
        for (int i = 0; i < 8; i++) begin
            push_en   = 1'b1;
            push_word = words[i];
            @(negedge clock);
        end
        push_en = 1'b0;
        n = 0;
        while (served < 17 && n < 400) begin
            @(negedge clock);
            n++;
        end
        bus.reqin = 1'b0;
        @(negedge clock);
        sb_on = 1'b0;
        chk("stream_cnt", served, 17);
        chk("stream_viol", viol, 0);
        chk("stream_bc", bus.bitcount, 7'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
